// File: rtl/timed_value_pkg.sv
// Shared types for the timed value driver: command beat layout and sequencer states.
package timed_value_pkg;

    localparam int TVD_VALUE_W = 32;
    localparam int TVD_DELAY_W = 16;

    typedef struct packed {
        logic [TVD_DELAY_W-1:0] delay;
        logic [TVD_VALUE_W-1:0] value;
    } tvd_cmd_t;

    typedef enum logic [0:0] {
        TVD_IDLE,
        TVD_RUN
    } tvd_state_t;

endpackage

// File: rtl/tvd_cmd_fifo.sv
// Command FIFO with first-word fall-through head and a sync flush.
module tvd_cmd_fifo #(
    parameter int W     = 48,
    parameter int DEPTH = 4,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [AW:0]   count_o
);

    logic [W-1:0] mem_q [DEPTH];
    logic [AW:0]  wr_q, wr_d;
    logic [AW:0]  rd_q, rd_d;

    always_comb begin
        wr_d = wr_q;
        rd_d = rd_q;
        if (flush_i) begin
            wr_d = '0;
            rd_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_q[AW-1:0]] <= data_i;
    end

    // Extra pointer MSB distinguishes full from empty.
    assign count_o = wr_q - rd_q;
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign empty_o = (wr_q == rd_q);
    assign data_o  = mem_q[rd_q[AW-1:0]];

endmodule

// File: rtl/timed_value_driver.sv
// Drives a value bus through queued (delay, value) commands with cycle-exact spacing.
module timed_value_driver
    import timed_value_pkg::*;
#(
    parameter int VALUE_W = TVD_VALUE_W,
    parameter int DELAY_W = TVD_DELAY_W,
    parameter int DEPTH   = 4,
    parameter logic [VALUE_W-1:0] RESET_VALUE = '0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     cmd_valid,
    output logic                     cmd_ready,
    input  logic [DELAY_W-1:0]       cmd_delay,
    input  logic [VALUE_W-1:0]       cmd_value,
    output logic [VALUE_W-1:0]       value,
    output logic                     value_upd,
    output logic                     done,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   cmd_count
);

    localparam int W = DELAY_W + VALUE_W;

    logic [W-1:0]       head;
    logic [DELAY_W-1:0] head_delay;
    logic [VALUE_W-1:0] head_value;
    logic [DELAY_W-1:0] load;
    logic               full, empty;
    logic               push, pop, apply;

    tvd_state_t         state_q;
    logic [DELAY_W-1:0] cnt_q;
    logic [VALUE_W-1:0] held_q;
    logic [VALUE_W-1:0] value_q;
    logic               upd_q;
    logic               done_q;

    assign cmd_ready = !full && !flush && !rst;
    assign push      = cmd_valid && cmd_ready;

    assign head_delay = head[W-1:VALUE_W];
    assign head_value = head[VALUE_W-1:0];
    // A delay of 0 behaves like 1: the counter reload is De-1.
    assign load = (head_delay == '0) ? '0 : head_delay - 1'b1;

    assign apply = (state_q == TVD_RUN) && (cnt_q == '0)
                   && !flush && !rst;
    assign pop   = !flush && !rst && !empty
                   && ((state_q == TVD_IDLE) || apply);

    tvd_cmd_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  ({cmd_delay, cmd_value}),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (cmd_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= TVD_IDLE;
            cnt_q   <= '0;
            held_q  <= '0;
            value_q <= RESET_VALUE;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else if (flush) begin
            state_q <= TVD_IDLE;
            cnt_q   <= '0;
            upd_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            upd_q  <= 1'b0;
            done_q <= 1'b0;
            unique case (state_q)
                TVD_IDLE: begin
                    if (!empty) begin
                        state_q <= TVD_RUN;
                        cnt_q   <= load;
                        held_q  <= head_value;
                    end
                end
                TVD_RUN: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        value_q <= held_q;
                        upd_q   <= 1'b1;
                        if (!empty) begin
                            cnt_q  <= load;
                            held_q <= head_value;
                        end else begin
                            done_q  <= 1'b1;
                            state_q <= TVD_IDLE;
                        end
                    end
                end
                default: state_q <= TVD_IDLE;
            endcase
        end
    end

    assign value     = value_q;
    assign value_upd = upd_q;
    assign done      = done_q;
    assign busy      = (state_q == TVD_RUN) || !empty;

endmodule
